// File: rtl/fpna_cfg_pkg.sv
// Shared types and helpers for the FPNA configuration chain.
package fpna_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_APPLY = 2'd2
  } cfg_state_e;

  // Integer ceiling division, used to size the shadow lanes.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/fpna_cfg_lane.sv
// One serial load lane: LEN-bit shift register, new bit enters at position 0.
module fpna_cfg_lane #(
  parameter int LEN = 33
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           din,
  output logic [LEN-1:0] q
);

  if (LEN == 1) begin : g_one
    // Single-stage lane: the stage simply captures the input.
    always_ff @(posedge clk) begin
      if (reset)   q <= '0;
      else if (en) q <= din;
    end
  end else begin : g_multi
    // Shift towards the top; the last stage falls off.
    always_ff @(posedge clk) begin
      if (reset)   q <= '0;
      else if (en) q <= {q[LEN-2:0], din};
    end
  end

endmodule

// File: rtl/fpna_config_chain.sv
// Configuration chain: CHAN parallel serial lanes load a shadow frame that is
// length-checked and copied to the active configuration on commit.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting; shadow and counter held
//   ST_SHIFT | config_en was high on the last edge, bits are streaming in
//   ST_APPLY | one-cycle transfer: copy shadow if length ok, else flag err
module fpna_config_chain
  import fpna_cfg_pkg::*;
#(
  parameter int CFG_BITS = 258,
  parameter int CHAN     = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                config_en,
  input  logic [CHAN-1:0]     bs_in,
  input  logic                commit,
  output logic [CHAN-1:0]     bs_out,
  output logic [CFG_BITS-1:0] cfg_out,
  output logic                cfg_valid,
  output logic                busy,
  output logic                err
);

  localparam int LANE_LEN = ceil_div(CFG_BITS, CHAN);
  localparam int FLAT     = CHAN * LANE_LEN;
  localparam int CNT_W    = $clog2(LANE_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LANE_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(LANE_LEN + 1);

  cfg_state_e          state, state_nxt;
  logic [CNT_W-1:0]    shift_cnt;
  logic [FLAT-1:0]     shadow_flat;
  logic [CFG_BITS-1:0] active;
  logic                shift_fire;
  logic                frame_ok;
  logic                load_active;
  logic                flag_err;

  // Shifting is frozen during the transfer cycle.
  assign shift_fire = config_en && (state != ST_APPLY);
  assign frame_ok   = (shift_cnt == CNT_FULL);

  for (genvar k = 0; k < CHAN; k++) begin : g_lane
    fpna_cfg_lane #(.LEN(LANE_LEN)) u_lane (
      .clk   (clk),
      .reset (reset),
      .en    (shift_fire),
      .din   (bs_in[k]),
      .q     (shadow_flat[k*LANE_LEN +: LANE_LEN])
    );
    assign bs_out[k] = shadow_flat[k*LANE_LEN + LANE_LEN - 1];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: enable wins over commit, APPLY lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_SHIFT: begin
        if (config_en)   state_nxt = ST_SHIFT;
        else if (commit) state_nxt = ST_APPLY;
        else             state_nxt = ST_IDLE;
      end
      ST_APPLY: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs and transfer decisions decoded from the current state.
  always_comb begin
    busy        = (state == ST_SHIFT) || (state == ST_APPLY);
    load_active = (state == ST_APPLY) && frame_ok;
    flag_err    = ((state == ST_APPLY) && !frame_ok) || (commit && shift_fire);
  end

  // Shift counter: counts enabled cycles, saturates one past a full frame.
  always_ff @(posedge clk) begin
    if (reset)                                shift_cnt <= '0;
    else if (state == ST_APPLY)               shift_cnt <= '0;
    else if (shift_fire && shift_cnt != CNT_SAT) shift_cnt <= shift_cnt + CNT_W'(1);
  end

  // Active configuration and status flags; err is sticky until a good commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      active    <= '0;
      cfg_valid <= 1'b0;
      err       <= 1'b0;
    end else if (load_active) begin
      active    <= shadow_flat[CFG_BITS-1:0];
      cfg_valid <= 1'b1;
      err       <= 1'b0;
    end else if (flag_err) begin
      err       <= 1'b1;
    end
  end

  assign cfg_out = active;

endmodule

// File: tb/tb_fpna_config_chain.sv
// Bench for fpna_config_chain: one single-lane and one four-lane instance,
// checked against a frame-level model built from per-lane bit histories.
module tb_fpna_config_chain;

  localparam int CFG_BITS = 258;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic en0, cm0, en1, cm1;
  logic [0:0] bsi0, bso0;
  logic [3:0] bsi1, bso1;
  logic [CFG_BITS-1:0] cfg0, cfg1;
  logic val0, val1, busy0, busy1, err0, err1;

  fpna_config_chain #(.CFG_BITS(CFG_BITS), .CHAN(1)) dut0 (
    .clk(clk), .reset(reset), .config_en(en0), .bs_in(bsi0), .commit(cm0),
    .bs_out(bso0), .cfg_out(cfg0), .cfg_valid(val0), .busy(busy0), .err(err0));

  fpna_config_chain #(.CFG_BITS(CFG_BITS), .CHAN(4)) dut1 (
    .clk(clk), .reset(reset), .config_en(en1), .bs_in(bsi1), .commit(cm1),
    .bs_out(bso1), .cfg_out(cfg1), .cfg_valid(val1), .busy(busy1), .err(err1));

  int errors = 0;
  int checks = 0;

  // Model: every bit ever sent on each lane since reset, plus frame-level state.
  bit               hist [2][4][$];
  int               cnt  [2];
  logic [CFG_BITS-1:0] act [2];
  bit               mval [2];
  bit               merr [2];

  function automatic int nch(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int lane_len(input int d);
    return (CFG_BITS + nch(d) - 1) / nch(d);
  endfunction

  // Position p of a lane holds the bit sent p shifts ago.
  function automatic logic [CFG_BITS-1:0] model_shadow(input int d);
    logic [CFG_BITS-1:0] v;
    int L;
    v = '0;
    L = lane_len(d);
    for (int i = 0; i < CFG_BITS; i++) begin
      int k; int p; int idx;
      k = i / L;
      p = i % L;
      idx = hist[d][k].size() - 1 - p;
      if (idx >= 0) v[i] = hist[d][k][idx];
    end
    return v;
  endfunction

  function automatic logic [3:0] model_bso(input int d);
    logic [3:0] v;
    int L; int sz;
    v = '0;
    L = lane_len(d);
    for (int k = 0; k < nch(d); k++) begin
      sz = hist[d][k].size();
      if (sz >= L) v[k] = hist[d][k][sz - L];
    end
    return v;
  endfunction

  function automatic logic [CFG_BITS-1:0] get_cfg(input int d);
    return (d == 0) ? cfg0 : cfg1;
  endfunction
  function automatic logic [3:0] get_bso(input int d);
    return (d == 0) ? {3'b000, bso0} : bso1;
  endfunction
  function automatic logic get_val(input int d);
    return (d == 0) ? val0 : val1;
  endfunction
  function automatic logic get_err(input int d);
    return (d == 0) ? err0 : err1;
  endfunction
  function automatic logic get_busy(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction

  task automatic check(input string tag, input logic [CFG_BITS-1:0] obs,
                       input logic [CFG_BITS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input int d, input string tag, input bit exp_busy);
    check({tag, "/cfg_out"},   get_cfg(d),  act[d]);
    check({tag, "/cfg_valid"}, get_val(d),  mval[d]);
    check({tag, "/err"},       get_err(d),  merr[d]);
    check({tag, "/busy"},      get_busy(d), exp_busy);
    check({tag, "/bs_out"},    get_bso(d),  model_bso(d));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input bit e, input bit c, input logic [3:0] b);
    if (d == 0) begin en0 = e; cm0 = c; bsi0 = b[0]; end
    else        begin en1 = e; cm1 = c; bsi1 = b;    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) hist[d][k].delete();
      cnt[d] = 0; act[d] = '0; mval[d] = 1'b0; merr[d] = 1'b0;
    end
  endtask

  task automatic model_shift(input int d, input logic [3:0] b);
    for (int k = 0; k < nch(d); k++) hist[d][k].push_back(b[k]);
    if (cnt[d] < lane_len(d) + 1) cnt[d]++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 4'h0);
    drive(1, 0, 0, 4'h0);
    cyc();
    reset = 1'b0;
    model_reset();
  endtask

  // Streams n bits; leaves config_en low afterwards without advancing time.
  task automatic shift_bits(input int d, input int n, input bit pattern,
                            output logic [3:0] first);
    logic [7:0] pat;
    logic [3:0] b;
    pat = 8'hA5;
    first = '0;
    for (int j = 0; j < n; j++) begin
      b = pattern ? {4{pat[j % 8]}} : 4'($urandom);
      if (j == 0) first = b;
      drive(d, 1, 0, b);
      model_shift(d, b);
      cyc();
    end
    drive(d, 0, 0, 4'h0);
  endtask

  // Commit pulse; noisy holds commit and config_en high through APPLY.
  task automatic commit_frame(input int d, input bit noisy, input string tag);
    drive(d, 0, 1, 4'h0);
    cyc();
    check({tag, "/apply_busy"}, get_busy(d), 1'b1);
    check({tag, "/apply_cfg_hold"}, get_cfg(d), act[d]);
    if (noisy) drive(d, 1, 1, 4'($urandom));
    else       drive(d, 0, 0, 4'h0);
    cyc();
    drive(d, 0, 0, 4'h0);
    if (cnt[d] == lane_len(d)) begin
      act[d] = model_shadow(d); mval[d] = 1'b1; merr[d] = 1'b0;
    end else begin
      merr[d] = 1'b1;
    end
    cnt[d] = 0;
    check_outs(d, tag, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] first;
    logic [CFG_BITS-1:0] exp_pat;
    logic [7:0] pat;
    pat = 8'hA5;

    do_reset();
    cyc();
    check_outs(0, "reset0", 1'b0);
    check_outs(1, "reset1", 1'b0);

    // Full 0xA5 frame on the single-lane chain.
    shift_bits(0, 258, 1'b1, first);
    check("shift_busy", busy0, 1'b1);
    commit_frame(0, 1'b0, "a5_frame");
    for (int i = 0; i < CFG_BITS; i++) exp_pat[i] = pat[(257 - i) % 8];
    check("a5_pattern", cfg0, exp_pat);

    // Short and long frames from reset.
    do_reset();
    shift_bits(0, 257, 1'b0, first);
    commit_frame(0, 1'b0, "short_frame");
    shift_bits(0, 259, 1'b0, first);
    commit_frame(0, 1'b0, "long_frame");
    shift_bits(0, 258, 1'b0, first);
    commit_frame(0, 1'b0, "good_after_err");

    // Commit colliding with config_en: error, shift still happens, no transfer.
    drive(0, 1, 1, 4'($urandom));
    model_shift(0, {3'b000, bsi0});
    merr[0] = 1'b1;
    cyc();
    drive(0, 0, 0, 4'h0);
    check_outs(0, "collide", 1'b1);
    commit_frame(0, 1'b0, "collide_partial");
    shift_bits(0, 258, 1'b0, first);
    commit_frame(0, 1'b0, "collide_recover");

    // Commit and config_en held through APPLY are ignored.
    shift_bits(0, 258, 1'b0, first);
    commit_frame(0, 1'b1, "noisy_apply");
    shift_bits(0, 258, 1'b0, first);
    commit_frame(0, 1'b0, "after_noisy");

    // Idle gap mid-frame keeps the count.
    shift_bits(0, 100, 1'b0, first);
    cyc(); cyc(); cyc();
    check("gap_idle_busy", busy0, 1'b0);
    shift_bits(0, 158, 1'b0, first);
    commit_frame(0, 1'b0, "gap_frame");

    // Four lanes, 65 shifts per frame, padding dropped.
    shift_bits(1, 65, 1'b0, first);
    check("lane_first_bit", bso1, first);
    commit_frame(1, 1'b0, "quad_frame");
    shift_bits(1, 64, 1'b0, first);
    commit_frame(1, 1'b0, "quad_short");
    shift_bits(1, 66, 1'b0, first);
    commit_frame(1, 1'b0, "quad_long");
    shift_bits(1, 65, 1'b0, first);
    commit_frame(1, 1'b0, "quad_recover");

    // Reset at shift 100 with config_en still high.
    shift_bits(0, 100, 1'b0, first);
    drive(0, 1, 0, 4'($urandom));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    drive(0, 0, 0, 4'h0);
    model_reset();
    check_outs(0, "reset_mid_shift", 1'b0);
    check_outs(1, "reset_mid_shift_q", 1'b0);
    shift_bits(0, 258, 1'b1, first);
    commit_frame(0, 1'b0, "post_reset_frame");
    check("post_reset_pattern", cfg0, exp_pat);

    // Reset during APPLY wipes the pending transfer.
    shift_bits(0, 258, 1'b0, first);
    drive(0, 0, 1, 4'h0);
    cyc();
    drive(0, 0, 0, 4'h0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    model_reset();
    check_outs(0, "reset_in_apply", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpna_config_chain.md
FPNA_CONFIG_CHAIN -- requirements
Module: fpna_config_chain

Interface
REQ-001 SHALL have parameter CFG_BITS, default 258: number of configuration bits delivered to the fabric.
REQ-002 SHALL have parameter CHAN, default 1, legal range 1..8: number of parallel serial load lanes.
REQ-003 SHALL derive LANE_LEN = ceil(CFG_BITS/CHAN), the shift cycles per complete frame; CHAN*LANE_LEN-CFG_BITS padding bits are discarded.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 config_en  in  1  shift enable; each high cycle shifts one bit into every lane.
REQ-007 bs_in  in  CHAN  serial data; bit k feeds lane k.
REQ-008 commit  in  1  single-cycle request to transfer the shadow frame to the active configuration.
REQ-009 bs_out  out  CHAN  serial readback/chaining; bit k is the last stage of lane k.
REQ-010 cfg_out  out  CFG_BITS  active configuration driving the fabric.
REQ-011 cfg_valid  out  1  high while cfg_out holds a committed, length-checked frame.
REQ-012 busy  out  1  high in SHIFT and APPLY states.
REQ-013 err  out  1  sticky frame error flag.

Function
REQ-014 SHALL hold a shadow shift register of CHAN lanes x LANE_LEN bits, separate from the active register behind cfg_out.
REQ-015 On a clock with config_en=1, each lane SHALL shift: bs_in[k] enters position 0, position p moves to p+1, position LANE_LEN-1 is dropped.
REQ-016 bs_out[k] SHALL equal lane k position LANE_LEN-1, registered, with no extra delay.
REQ-017 Mapping SHALL be cfg_out[k*LANE_LEN+p] = lane k position p, for indices below CFG_BITS.
REQ-018 A shift counter SHALL count config_en cycles since the last commit or reset, saturating at LANE_LEN+1.
REQ-019 FSM states SHALL be IDLE, SHIFT and APPLY.
REQ-020 IDLE -> SHIFT on config_en=1.
REQ-021 SHIFT -> IDLE when config_en=0 and commit=0; the counter is held.
REQ-022 IDLE or SHIFT with commit=1 and config_en=0 -> APPLY.
REQ-023 In APPLY, if the counter equals LANE_LEN, SHALL copy shadow to active, set cfg_valid=1 and clear err; otherwise SHALL set err=1 and leave the active register and cfg_valid unchanged.
REQ-024 In both APPLY cases, SHALL clear the counter and return to IDLE after one cycle.
REQ-025 cfg_out SHALL update on the edge that leaves APPLY, giving commit-to-cfg_out latency of 2 clocks.
REQ-026 commit=1 together with config_en=1 SHALL set err=1, SHALL NOT commit, and the shift still occurs.
REQ-027 commit while in APPLY SHALL be ignored.
REQ-028 config_en while in APPLY SHALL be ignored: no shift and no count.
REQ-029 The shadow register SHALL retain its contents after a commit; only the counter restarts.
REQ-030 err SHALL stay set until reset or a successful commit.

Reset
REQ-031 On reset=1 at a clock edge: state=IDLE, counter=0, shadow=0, active=0, cfg_out=0, bs_out=0, cfg_valid=0, err=0, busy=0.
REQ-032 Reset SHALL override all other inputs, including mid-shift and during APPLY.

Structure
REQ-033 Shared package fpna_cfg_pkg SHALL hold the FSM state enum and a ceil-divide function used for LANE_LEN.
REQ-034 One sub-module, fpna_cfg_lane (a LANE_LEN-bit serial shift register with enable), SHALL be instantiated CHAN times via generate.

Verification
REQ-035 CFG_BITS=258, CHAN=1: shift 258 bits of 0xA5 pattern, then commit -> cfg_valid=1 and cfg_out matches the pattern exactly 2 clocks after commit, err=0.
REQ-036 CFG_BITS=258, CHAN=1: 257 shifts then commit -> err=1, cfg_valid=0, cfg_out=0; 259 shifts then commit -> err=1 as well.
REQ-037 CFG_BITS=258, CHAN=4: LANE_LEN=65; 65 shifts then commit -> cfg_valid=1, 2 padding bits discarded, bs_out[k] shows the first bit sent on lane k after 65 shifts.
REQ-038 commit asserted together with config_en -> err=1, active configuration unchanged; a later valid 258-shift frame plus commit clears err.
REQ-039 Reset asserted at shift 100 -> next cycle counter=0, busy=0, cfg_out=0; a fresh 258-bit frame then commits correctly.
